// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/subtract unit that reuses one 4-bit carry-lookahead
// slice, walking the operands one nibble per clock from the LSB upward.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic              carry;

  logic [3:0] nib_a, nib_b, gen, prop, slice_sum;
  logic [4:0] slice_c;

  // Shared slice: carries are computed in parallel from generate/propagate terms.
  always_comb begin
    nib_a      = op_a[4*int'(idx) +: 4];
    nib_b      = op_b[4*int'(idx) +: 4];
    gen        = nib_a & nib_b;
    prop       = nib_a ^ nib_b;
    slice_c    = '0;
    slice_c[0] = carry;
    slice_c[1] = gen[0] | (prop[0] & carry);
    slice_c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carry);
    slice_c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
               | (prop[2] & prop[1] & prop[0] & carry);
    slice_c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
               | (prop[3] & prop[2] & prop[1] & gen[0])
               | (prop[3] & prop[2] & prop[1] & prop[0] & carry);
    slice_sum  = prop ^ slice_c[3:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      s        <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, so the inverted operand and forced carry are latched here.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : c_in;
            s     <= '0;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s[4*int'(idx) +: 4] <= slice_sum;
          carry               <= slice_c[4];
          if (idx == IDXW'(NIB - 1)) begin
            c_out    <= slice_c[4];
            overflow <= slice_c[3] ^ slice_c[4];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl (WIDTH=16), with
// expected results worked out by hand for each operation.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             overflow;

  int tests = 0;
  int fails = 0;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .busy     (busy),
    .done     (done),
    .s        (s),
    .c_out    (c_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one request from a negedge and returns just after the accept edge.
  task automatic applyStimulus(input logic op_sub, input logic [WIDTH-1:0] op_a,
                               input logic [WIDTH-1:0] op_b, input logic op_cin,
                               input logic keep_start);
    start = 1'b1;
    sub   = op_sub;
    a     = op_a;
    b     = op_b;
    c_in  = op_cin;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
  endtask

  // Called right after the accept edge: checks busy window, done pulse and result.
  task automatic waitResult(input string tag, input logic [WIDTH-1:0] exp_s,
                            input logic exp_c, input logic exp_ov);
    for (int i = 0; i < NIB; i++) begin
      @(negedge clk);
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " done early"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " busy at done"}, 32'(busy), 32'd0);
    checkOutput({tag, " s"}, 32'(s), 32'(exp_s));
    checkOutput({tag, " c_out"}, 32'(c_out), 32'(exp_c));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(exp_ov));
    @(negedge clk);
    checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
    checkOutput({tag, " s held"}, 32'(s), 32'(exp_s));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    c_in  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset s", 32'(s), 32'd0);
    checkOutput("reset c_out", 32'(c_out), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    waitResult("add 1234+4321", 16'h5555, 1'b0, 1'b0);

    applyStimulus(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    waitResult("add FFFF+0001", 16'h0000, 1'b1, 1'b0);

    applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    waitResult("add 7FFF+0001", 16'h8000, 1'b0, 1'b1);

    applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0);
    waitResult("sub 8000-0001", 16'h7FFF, 1'b1, 1'b1);

    applyStimulus(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b0);
    waitResult("sub 0003-0005", 16'hFFFE, 1'b0, 1'b0);

    applyStimulus(1'b1, 16'h0003, 16'h0005, 1'b1, 1'b0);
    waitResult("sub cin1 0003-0005", 16'hFFFE, 1'b0, 1'b0);

    // A second start during RUN must be dropped, not queued.
    applyStimulus(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ignore busy", 32'(busy), 32'd1);
    start = 1'b1;
    sub   = 1'b1;
    a     = 16'h1111;
    b     = 16'h2222;
    c_in  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore busy 2", 32'(busy), 32'd1);
    repeat (NIB - 2) @(negedge clk);
    checkOutput("ignore busy last", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("ignore done", 32'(done), 32'd1);
    checkOutput("ignore s", 32'(s), 32'h0001);
    checkOutput("ignore c_out", 32'(c_out), 32'd0);
    for (int i = 0; i < NIB + 2; i++) begin
      @(negedge clk);
      checkOutput("ignore no second done", 32'(done), 32'd0);
      checkOutput("ignore idle", 32'(busy), 32'd0);
    end

    // Reset lands after nibble 1 has been written; the operation must vanish.
    applyStimulus(1'b0, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun rst busy", 32'(busy), 32'd0);
    checkOutput("midrun rst done", 32'(done), 32'd0);
    checkOutput("midrun rst s", 32'(s), 32'd0);
    checkOutput("midrun rst c_out", 32'(c_out), 32'd0);
    for (int i = 0; i < NIB + 1; i++) begin
      @(negedge clk);
      checkOutput("midrun rst no done", 32'(done), 32'd0);
      checkOutput("midrun rst idle", 32'(busy), 32'd0);
    end
    applyStimulus(1'b0, 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    waitResult("add 0F0F+00F1", 16'h1000, 1'b0, 1'b0);

    // start held high: next accept only after DONE returns to IDLE.
    applyStimulus(1'b0, 16'h1234, 16'h1111, 1'b0, 1'b1);
    sub = 1'b1;
    a   = 16'h0010;
    b   = 16'h0020;
    waitResult("b2b first", 16'h2345, 1'b0, 1'b0);
    checkOutput("b2b idle gap", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitResult("b2b second", 16'hFFF0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
